// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding and the default IR value used in reset and after a flush.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_IR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: PC stage, instruction memory and decode handshakes in one bundle.
// master = fetch unit (drives o*), slave = surrounding pipeline and memory (drives i*).
interface fetch_unit_if;

  logic [31:0] iPC;
  logic        oPCEn;
  logic [31:0] oMemAddr;
  logic        oMemRd;
  logic [31:0] iMemData;
  logic        iMemRdy;
  logic        iFlush;
  logic [31:0] oIR;
  logic [31:0] oIRPC;
  logic        oValid;
  logic        iReady;
  logic [31:0] oFetchCnt;

  modport master (
    input  iPC, iMemData, iMemRdy, iFlush, iReady,
    output oPCEn, oMemAddr, oMemRd, oIR, oIRPC, oValid, oFetchCnt
  );

  modport slave (
    output iPC, iMemData, iMemRdy, iFlush, iReady,
    input  oPCEn, oMemAddr, oMemRd, oIR, oIRPC, oValid, oFetchCnt
  );

endinterface

// File: rtl/fetch_unit_reg32.sv
// 32-bit enabled register with asynchronous active-low reset to a parameterised value.
// One cycle latency from en_i/d_i to q_o; no backpressure.
module REG32 #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one memory read per instruction, held for decode until iReady, flushable.
// Word reaches decode one cycle after the memory accept; iReady=0 stalls in S_HOLD with no new reads.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_IR = RESET_IR_DEFAULT
) (
  input  logic         iClk,
  input  logic         nRst,
  fetch_unit_if.master bus
);

  fetch_state_t state_q;
  logic [31:0]  addr_q;
  logic [31:0]  cnt_q;
  logic         mem_rd_q;
  logic         valid_q;

  logic         accept;
  logic         hold_flush;
  logic         ir_en;
  logic [31:0]  ir_d;

  // The only cycle that consumes a fetched word; it also advances the PC stage.
  assign accept     = (state_q == S_REQ) && bus.iMemRdy && !bus.iFlush;
  assign hold_flush = (state_q == S_HOLD) && bus.iFlush;
  assign ir_en      = accept || hold_flush;
  assign ir_d       = accept ? bus.iMemData : RESET_IR;

  REG32 #(.RST_VAL(RESET_IR)) u_ir (
    .clk_i   (iClk),
    .rst_n_i (nRst),
    .en_i    (ir_en),
    .d_i     (ir_d),
    .q_o     (bus.oIR)
  );

  REG32 #(.RST_VAL(32'h0000_0000)) u_irpc (
    .clk_i   (iClk),
    .rst_n_i (nRst),
    .en_i    (accept),
    .d_i     (addr_q),
    .q_o     (bus.oIRPC)
  );

  assign bus.oPCEn     = accept;
  assign bus.oMemAddr  = addr_q;
  assign bus.oMemRd    = mem_rd_q;
  assign bus.oValid    = valid_q;
  assign bus.oFetchCnt = cnt_q;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0000_0000;
      cnt_q    <= 32'h0000_0000;
      mem_rd_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_q   <= bus.iPC;
          mem_rd_q <= 1'b1;
          state_q  <= S_REQ;
        end
        S_REQ: begin
          if (bus.iMemRdy) begin
            if (bus.iFlush) begin
              addr_q <= bus.iPC;
            end else begin
              mem_rd_q <= 1'b0;
              valid_q  <= 1'b1;
              state_q  <= S_HOLD;
            end
          end else if (bus.iFlush) begin
            // Memory handshake cannot be aborted, so wait out the stale read.
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (bus.iMemRdy) begin
            addr_q  <= bus.iPC;
            state_q <= S_REQ;
          end
        end
        S_HOLD: begin
          if (bus.iFlush || bus.iReady) begin
            valid_q  <= 1'b0;
            addr_q   <= bus.iPC;
            mem_rd_q <= 1'b1;
            state_q  <= S_REQ;
            if (!bus.iFlush) begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          mem_rd_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: RESET_IR, default 32'h00000000, IR value held in reset and after flush.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 iClk  in  1  rising-edge clock.
REQ-004 nRst  in  1  asynchronous active-low reset.
REQ-005 iPC  in  32  current program counter from PC stage.
REQ-006 oPCEn  out  1  one-cycle enable that advances the PC stage.
REQ-007 oMemAddr  out  32  instruction memory read address.
REQ-008 oMemRd  out  1  read request, held until accepted.
REQ-009 iMemData  in  32  instruction word, valid when iMemRdy=1.
REQ-010 iMemRdy  in  1  memory completes the current read.
REQ-011 iFlush  in  1  discard held/in-flight instruction (taken branch).
REQ-012 oIR  out  32  fetched instruction to decode.
REQ-013 oIRPC  out  32  address that oIR was fetched from.
REQ-014 oValid  out  1  oIR/oIRPC valid for decode.
REQ-015 iReady  in  1  decode accepts oIR this cycle.
REQ-016 oFetchCnt  out  32  count of instructions delivered (oValid&&iReady).

Function
REQ-017 FSM states SHALL be S_IDLE, S_REQ, S_HOLD, S_DROP.
REQ-018 S_IDLE: oMemRd=0; next edge -> S_REQ, address register <= iPC.
REQ-019 S_REQ: oMemRd=1, oMemAddr = address register, stable until iMemRdy.
REQ-020 S_REQ with iMemRdy=1 and iFlush=0: oPCEn=1 combinationally that cycle; on the edge oIR<=iMemData, oIRPC<=address register, oValid<=1, -> S_HOLD.
REQ-021 S_REQ with iFlush=1 and iMemRdy=0: -> S_DROP, oMemRd stays 1 (memory handshake never aborted).
REQ-022 S_REQ with iFlush=1 and iMemRdy=1: data discarded, oPCEn=0, address register <= iPC, stay S_REQ.
REQ-023 S_DROP: oMemRd=1; on iMemRdy data discarded, oPCEn=0, address register <= iPC, -> S_REQ.
REQ-024 S_HOLD: oValid=1, oIR/oIRPC stable while iReady=0.
REQ-025 S_HOLD with iReady=1, iFlush=0: oValid<=0, oFetchCnt+1, address register <= iPC, -> S_REQ (one idle bus cycle per instruction).
REQ-026 S_HOLD with iFlush=1: oValid<=0, oIR<=RESET_IR, address register <= iPC, -> S_REQ; iFlush wins over iReady, no count.
REQ-027 oPCEn SHALL be asserted only per REQ-020; never in S_IDLE, S_HOLD, S_DROP.
REQ-028 oFetchCnt SHALL wrap 32'hFFFFFFFF -> 0 without flag.
REQ-029 oMemAddr SHALL equal the address register in all states; oMemRd=0 outside S_REQ/S_DROP.

Reset
REQ-030 nRst=0 SHALL immediately force S_IDLE, oMemRd=0, oPCEn=0, oValid=0, oIR=RESET_IR, oIRPC=0, address register=0, oFetchCnt=0.
REQ-031 Reset mid-request SHALL abandon the read; memory is reset by the same nRst.
REQ-032 First request after reset SHALL occur in the second cycle after nRst release, at PC reset address.

Structure
REQ-033 State encodings and RESET_IR default SHALL live in shared package fetch_pkg.
REQ-034 oIR/oIRPC storage SHALL use existing sub-module REG32; FSM, address register and counter are local.

Verification
REQ-035 Reset release, iPC=0, iMemRdy=1 in first S_REQ, iMemData=32'h12345678 -> oMemAddr=0, oPCEn pulse once, next cycle oValid=1, oIR=32'h12345678, oIRPC=0.
REQ-036 Memory 3 wait states at addr 0x04 -> oMemRd held 4 cycles, oMemAddr=0x04 stable, single oPCEn on the accept cycle.
REQ-037 iReady=0 for 5 cycles in S_HOLD -> oIR/oIRPC unchanged, no new oMemRd, oFetchCnt unchanged; iReady=1 -> count+1, request at new iPC.
REQ-038 iFlush during 2nd wait cycle, iPC then 0x100 -> S_DROP, returned word discarded, no oPCEn, next request addr=0x100.
REQ-039 iFlush and iReady both 1 in S_HOLD -> oValid=0, oIR=RESET_IR, oFetchCnt unchanged.
REQ-040 nRst pulsed low while oMemRd=1 -> all outputs at reset values asynchronously; restart per REQ-032.
